// File: rtl/mmio_console_pkg.sv
// mmio_console_pkg: register offsets, STATUS bit positions and TX FSM states
// shared by the memory-mapped console and its bench.
package mmio_console_pkg;

    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] TOHOST_OFF = 4'h8;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_BUSY_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 4;

    localparam logic [31:0] STATUS_COUNT_MASK = 32'h0000_00F0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/mmio_console_byte_fifo.sv
// byte_fifo: synchronous byte FIFO, power-of-two depth, head visible
// combinationally on dout. A push on a full FIFO is accepted only when a pop
// happens in the same cycle; pops on an empty FIFO are ignored.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console/exit device. Stores to TXDATA are
// queued and sent LSB-first as 8N1 frames on tx; a store to TOHOST latches
// the exit code and raises done. Optional build macro MMIO_CONSOLE_ECHO_EN
// adds char_valid/char_data, a one-cycle echo of each byte as it is popped.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          BIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        done,
    output logic [31:0] exit_code
`ifdef MMIO_CONSOLE_ECHO_EN
    ,
    output logic        char_valid,
    output logic [7:0]  char_data
`endif
);

    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

    logic            sel_s;
    logic            txdata_wr_s;
    logic            tohost_wr_s;
    logic            ovf_set_s;
    logic            pop_s;
    logic [7:0]      fifo_dout_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [FCW-1:0]  fifo_count_s;
    logic [31:0]     status_s;
    logic [31:0]     read_data_s;

    tx_state_t       state_r, state_nx_s;
    logic [CYC_W-1:0] cyc_r, cyc_nx_s;
    logic [2:0]      bit_r, bit_nx_s;
    logic [7:0]      shift_r, shift_nx_s;
    logic            tx_r, tx_nx_s;
    logic            overflow_r;
    logic            done_r;
    logic [31:0]     exit_code_r;

    assign sel_s       = (address[31:4] == BASE_ADDR[31:4]);
    assign txdata_wr_s = sel_s && mem_write && (address[3:0] == TXDATA_OFF);
    assign tohost_wr_s = sel_s && mem_write && (address[3:0] == TOHOST_OFF);
    // A push onto a full FIFO survives only when the FSM pops the same cycle.
    assign ovf_set_s   = txdata_wr_s && fifo_full_s && !pop_s;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txdata_wr_s),
        .pop   (pop_s),
        .din   (write_data[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // STATUS word assembly: count field, overflow, busy, full.
    always_comb begin
        status_s = (32'(fifo_count_s) << STATUS_COUNT_LSB) & STATUS_COUNT_MASK;
        status_s[STATUS_FULL_BIT] = fifo_full_s;
        status_s[STATUS_BUSY_BIT] = (state_r != IDLE);
        status_s[STATUS_OVF_BIT]  = overflow_r;
    end

    // Load mux: only STATUS returns data; everything else reads as zero.
    always_comb begin
        read_data_s = 32'h0000_0000;
        if (sel_s && mem_read) begin
            case (address[3:0])
                STATUS_OFF: read_data_s = status_s;
                default:    read_data_s = 32'h0000_0000;
            endcase
        end else begin
            read_data_s = 32'h0000_0000;
        end
    end

    assign read_data = read_data_s;

    // TX FSM next-state: frame timing, FIFO pop and next serial bit.
    always_comb begin
        state_nx_s = state_r;
        cyc_nx_s   = cyc_r;
        bit_nx_s   = bit_r;
        shift_nx_s = shift_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                cyc_nx_s = {CYC_W{1'b0}};
                bit_nx_s = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    shift_nx_s = fifo_dout_s;
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (cyc_r == CYC_LAST) begin
                    cyc_nx_s   = {CYC_W{1'b0}};
                    bit_nx_s   = 3'd0;
                    state_nx_s = DATA;
                end else begin
                    cyc_nx_s = cyc_r + CYC_ONE;
                end
            end
            DATA: begin
                if (cyc_r == CYC_LAST) begin
                    cyc_nx_s = {CYC_W{1'b0}};
                    if (bit_r == 3'd7) begin
                        state_nx_s = STOP;
                    end else begin
                        shift_nx_s = {1'b0, shift_r[7:1]};
                        bit_nx_s   = bit_r + 3'd1;
                    end
                end else begin
                    cyc_nx_s = cyc_r + CYC_ONE;
                end
            end
            STOP: begin
                if (cyc_r == CYC_LAST) begin
                    cyc_nx_s = {CYC_W{1'b0}};
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty_s) begin
                        pop_s      = 1'b1;
                        shift_nx_s = fifo_dout_s;
                        state_nx_s = START;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    cyc_nx_s = cyc_r + CYC_ONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cyc_nx_s   = {CYC_W{1'b0}};
                bit_nx_s   = 3'd0;
            end
        endcase
        // tx is registered, so it is derived from where the FSM is heading.
        case (state_nx_s)
            START:   tx_nx_s = 1'b0;
            DATA:    tx_nx_s = shift_nx_s[0];
            default: tx_nx_s = 1'b1;
        endcase
    end

    // TX FSM state, counters, shift register and registered serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cyc_r   <= {CYC_W{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            cyc_r   <= cyc_nx_s;
            bit_r   <= bit_nx_s;
            shift_r <= shift_nx_s;
            tx_r    <= tx_nx_s;
        end
    end

    // Sticky overflow flag and first-write-wins exit code.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            done_r      <= 1'b0;
            exit_code_r <= 32'h0000_0000;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end
            if (tohost_wr_s && !done_r) begin
                done_r      <= 1'b1;
                exit_code_r <= write_data;
            end
        end
    end

    assign tx        = tx_r;
    assign done      = done_r;
    assign exit_code = exit_code_r;

`ifdef MMIO_CONSOLE_ECHO_EN
    assign char_valid = pop_s;
    assign char_data  = pop_s ? fifo_dout_s : 8'h00;
`endif

endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: directed bench for mmio_console. A background decoder
// turns tx frames into bytes with their start cycle; scenario tasks drive the
// bus at the falling edge and compare against hand-computed values.
// Build with MMIO_CONSOLE_ECHO_EN to also exercise the echo outputs.
module tb_mmio_console;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int BC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        tx;
    logic        done;
    logic [31:0] exit_code;
`ifdef MMIO_CONSOLE_ECHO_EN
    logic        char_valid;
    logic [7:0]  char_data;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_stop[$];
    logic [7:0] dec_b;
    int         dec_t;

    mmio_console #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .BIT_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .tx         (tx),
        .done       (done),
        .exit_code  (exit_code)
`ifdef MMIO_CONSOLE_ECHO_EN
        ,
        .char_valid (char_valid),
        .char_data  (char_data)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Serial decoder: samples each bit in its middle, records byte/start/stop.
    initial begin : decoder
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                dec_t = cycle;
                repeat (BC / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (BC) @(negedge clk);
                    dec_b[j] = tx;
                end
                repeat (BC) @(negedge clk);
                rx_q.push_back(dec_b);
                rx_t.push_back(dec_t);
                rx_stop.push_back(tx);
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address = a;
        write_data = d;
        mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        address = a;
        mem_read = 1'b1;
        #1;
        d = read_data;
        mem_read = 1'b0;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        rx_stop.delete();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] st;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (exit_code !== 32'h0) begin n_fail++; $display("FAIL reset_exit: got %h expected 0", exit_code); end
        bus_read(BASE + 32'h4, st);
        n_checks++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 00000000", st); end
`ifdef MMIO_CONSOLE_ECHO_EN
        n_checks++;
        if (char_valid !== 1'b0 || char_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_echo: got %b/%h expected 0/00", char_valid, char_data);
        end
`endif
    endtask

    task automatic test_single_frame();
        logic [9:0]  fr;
        logic [31:0] st;
        fr = 10'b1_0100_0001_0;   // stop, 0x41 MSB..LSB, start
        @(negedge clk);
        bus_write(BASE, 32'h0000_0041);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL frame_pop_cycle: tx got %b expected 1", tx); end
        for (int i = 0; i < 10 * BC; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== fr[i / BC]) begin
                n_fail++; $display("FAIL frame_bit cyc %0d: tx got %b expected %b", i, tx, fr[i / BC]);
            end
            if (i == 20) begin
                bus_read(BASE + 32'h4, st);
                n_checks++;
                if (st !== 32'h2) begin n_fail++; $display("FAIL frame_busy: status got %h expected 00000002", st); end
            end
        end
        @(negedge clk);
        bus_read(BASE + 32'h4, st);
        n_checks++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL frame_idle: status got %h expected 00000000", st); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] st;
        logic [7:0]  exp_b [5];
        exp_b = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        clear_rx();
        @(negedge clk);
        for (int i = 0; i < 5; i++) bus_write(BASE, {24'h0, exp_b[i]});
        bus_read(BASE + 32'h4, st);
        n_checks++;
        if (st !== 32'h43) begin n_fail++; $display("FAIL b2b_status: got %h expected 00000043", st); end
        wait_frames(5, 400);
        n_checks++;
        if (rx_q.size() != 5) begin
            n_fail++; $display("FAIL b2b_count: got %0d frames expected 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (rx_q[i] !== exp_b[i] || rx_stop[i] !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_byte %0d: got %h stop %b expected %h stop 1", i, rx_q[i], rx_stop[i], exp_b[i]);
                end
                if (i > 0) begin
                    n_checks++;
                    if (rx_t[i] - rx_t[i-1] != 10 * BC) begin
                        n_fail++; $display("FAIL b2b_gap %0d: got %0d cycles expected %0d", i, rx_t[i] - rx_t[i-1], 10 * BC);
                    end
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] st;
        clear_rx();
        @(negedge clk);
        for (int i = 0; i < 6; i++) bus_write(BASE, 32'h60 + i);
        bus_read(BASE + 32'h4, st);
        n_checks++;
        if (st !== 32'h47) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000047", st); end
        wait_frames(5, 400);
        repeat (60) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 5) begin
            n_fail++; $display("FAIL ovf_frames: got %0d frames expected 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (rx_q[i] !== 8'(8'h60 + i)) begin
                    n_fail++; $display("FAIL ovf_byte %0d: got %h expected %h", i, rx_q[i], 8'(8'h60 + i));
                end
            end
        end
        bus_read(BASE + 32'h4, st);
        n_checks++;
        if (st !== 32'h4) begin n_fail++; $display("FAIL ovf_sticky: got %h expected 00000004", st); end
    endtask

    task automatic test_tohost();
        logic [31:0] rd;
        @(negedge clk);
        bus_write(BASE + 32'h8, 32'h0000_0001);
        n_checks++;
        if (done !== 1'b1 || exit_code !== 32'h1) begin
            n_fail++; $display("FAIL tohost_first: got done %b code %h expected 1 00000001", done, exit_code);
        end
        bus_write(BASE + 32'h8, 32'h0000_DEAD);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || exit_code !== 32'h1) begin
            n_fail++; $display("FAIL tohost_second: got done %b code %h expected 1 00000001", done, exit_code);
        end
        bus_read(BASE + 32'h8, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL tohost_read: got %h expected 0", rd); end
        bus_read(BASE + 32'hC, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reg_c_read: got %h expected 0", rd); end
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL tohost_no_tx: got %b expected 1", tx); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] st;
        clear_rx();
        @(negedge clk);
        bus_write(BASE, 32'h0000_0033);
        repeat (3 * BC + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        bus_read(BASE + 32'h4, st);
        n_checks++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status: got %h expected 00000000", st); end
        repeat (60) @(negedge clk);
        clear_rx();
        bus_write(BASE, 32'h0000_0055);
        wait_frames(1, 200);
        n_checks++;
        if (rx_q.size() != 1) begin
            n_fail++; $display("FAIL rst_mid_frames: got %0d expected 1", rx_q.size());
        end else if (rx_q[0] !== 8'h55 || rx_stop[0] !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_byte: got %h stop %b expected 55 stop 1", rx_q[0], rx_stop[0]);
        end
    endtask

    task automatic test_echo_unmapped();
        logic [31:0] rd;
        repeat (10) @(negedge clk);
        bus_read(BASE + 32'h100, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", rd); end
        clear_rx();
`ifdef MMIO_CONSOLE_ECHO_EN
        n_checks++;
        if (char_valid !== 1'b0) begin n_fail++; $display("FAIL echo_idle: got %b expected 0", char_valid); end
`endif
        bus_write(BASE, 32'h0000_007A);
`ifdef MMIO_CONSOLE_ECHO_EN
        n_checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h7A) begin
            n_fail++; $display("FAIL echo_pulse: got %b/%h expected 1/7a", char_valid, char_data);
        end
        @(negedge clk);
        n_checks++;
        if (char_valid !== 1'b0 || char_data !== 8'h00) begin
            n_fail++; $display("FAIL echo_after: got %b/%h expected 0/00", char_valid, char_data);
        end
`endif
        wait_frames(1, 200);
        n_checks++;
        if (rx_q.size() != 1) begin
            n_fail++; $display("FAIL echo_frames: got %0d expected 1", rx_q.size());
        end else if (rx_q[0] !== 8'h7A) begin
            n_fail++; $display("FAIL echo_byte: got %h expected 7a", rx_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_tohost();
        test_reset_mid_frame();
        test_echo_unmapped();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
